spi_slave_core: RTL and testbench

Synthesisable, parametrised SPI slave for the SPI core's bench and for on-chip slave endpoints. It runs entirely in the system clock domain, oversampling `sclk`, `mosi` and the slave-select pad through synchronisers. It supports both `rx_negedge`/`tx_negedge` combinations of the SPI core, MSB- or LSB-first transfers, characters of 1..128 bits, and back-to-back characters within one select window. Parallel data is exchanged through a one-deep transmit buffer and a receive strobe.

---
 rtl/spi_slave_core.sv | 203 ++++++++++++++++++++
 tb/tb_spi_slave_core.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// rtl/spi_slave_core.sv - oversampled SPI slave with one-deep tx buffer and rx strobe
// sclk, mosi and select are synchronised into wb_clk_i; every action runs on edge pulses.
module spi_slave_core #(
  parameter int CHAR_LEN = 8,
  parameter int SS_NB    = 8,
  parameter int SS_SEL   = 0
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                sclk_pad_i,
  input  logic                mosi_pad_i,
  input  logic [SS_NB-1:0]    ss_pad_i,
  output logic                miso_pad_o,
  input  logic                rx_negedge,
  input  logic                tx_negedge,
  input  logic                lsb,
  input  logic [CHAR_LEN-1:0] tx_data_i,
  input  logic                tx_we_i,
  output logic                tx_full_o,
  output logic [CHAR_LEN-1:0] rx_data_o,
  output logic                rx_valid_o,
  output logic                tx_underrun_o,
  output logic                abort_o,
  output logic                busy_o
);
  localparam int CW = $clog2(CHAR_LEN + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t              state_q, state_d;
  logic [2:0]          sclk_sync_q, sclk_sync_d;
  logic [2:0]          mosi_sync_q, mosi_sync_d;
  logic [1:0]          ss_sync_q, ss_sync_d;
  logic                rise_q, rise_d, fall_q, fall_d;
  logic [CHAR_LEN-1:0] buf_q, buf_d;
  logic                tx_full_q, tx_full_d;
  logic [CHAR_LEN-1:0] tx_sr_q, tx_sr_d;
  logic [CHAR_LEN-1:0] rx_sr_q, rx_sr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                armed_q, armed_d;
  logic                miso_q, miso_d;
  logic [CHAR_LEN-1:0] rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                tx_underrun_q, tx_underrun_d;
  logic                abort_q, abort_d;
  logic                busy_q, busy_d;

  logic                sample, launch, capture, do_load, load_ok, released;
  logic [CHAR_LEN-1:0] mosi_vec, rx_next, tx_shift, load_val;
  logic                unused_ss;

  assign unused_ss = ^ss_pad_i;

  always_comb begin
    sclk_sync_d   = {sclk_sync_q[1:0], sclk_pad_i};
    mosi_sync_d   = {mosi_sync_q[1:0], mosi_pad_i};
    ss_sync_d     = {ss_sync_q[0], ss_pad_i[SS_SEL]};
    rise_d        = sclk_sync_q[1] & ~sclk_sync_q[2];
    fall_d        = ~sclk_sync_q[1] & sclk_sync_q[2];
    released      = ss_sync_q[1];

    sample        = tx_negedge ? rise_q : fall_q;
    launch        = rx_negedge ? rise_q : fall_q;
    capture       = rx_negedge ? fall_q : rise_q;

    mosi_vec      = '0;
    mosi_vec[0]   = mosi_sync_q[2];
    rx_next       = lsb ? ((rx_sr_q >> 1) | (mosi_vec << (CHAR_LEN - 1)))
                        : ((rx_sr_q << 1) | mosi_vec);
    tx_shift      = lsb ? (tx_sr_q >> 1) : (tx_sr_q << 1);

    // A write landing in the same cycle as a load goes straight into the shifter.
    load_ok       = tx_we_i | tx_full_q;
    load_val      = tx_we_i ? tx_data_i : (tx_full_q ? buf_q : '0);

    state_d       = state_q;
    buf_d         = buf_q;
    tx_full_d     = tx_full_q;
    tx_sr_d       = tx_sr_q;
    rx_sr_d       = rx_sr_q;
    cnt_d         = cnt_q;
    armed_d       = armed_q;
    miso_d        = miso_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    abort_d       = 1'b0;
    busy_d        = ~ss_sync_q[1];
    do_load       = 1'b0;

    if (tx_we_i) begin
      buf_d     = tx_data_i;
      tx_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        miso_d  = 1'b0;
        cnt_d   = '0;
        armed_d = 1'b0;
        rx_sr_d = '0;
        if (!released) state_d = LOAD;
      end
      LOAD: begin
        if (released) begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end else begin
          do_load = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (released) begin
          state_d = IDLE;
          miso_d  = 1'b0;
          cnt_d   = '0;
          abort_d = (cnt_q != '0);
        end else begin
          if (sample) begin
            rx_sr_d = rx_next;
            if (cnt_q == CW'(CHAR_LEN - 1)) begin
              rx_data_d  = rx_next;
              rx_valid_d = 1'b1;
              cnt_d      = '0;
              do_load    = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          // The first launch edge after a load must not shift away the bit it just drove.
          if (!do_load) begin
            if (capture) armed_d = 1'b1;
            if (launch && armed_q) begin
              tx_sr_d = tx_shift;
              miso_d  = lsb ? tx_shift[0] : tx_shift[CHAR_LEN-1];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_load) begin
      tx_sr_d       = load_val;
      miso_d        = lsb ? load_val[0] : load_val[CHAR_LEN-1];
      armed_d       = 1'b0;
      tx_full_d     = 1'b0;
      tx_underrun_d = ~load_ok;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q       <= IDLE;
      sclk_sync_q   <= '0;
      mosi_sync_q   <= '0;
      ss_sync_q     <= '1;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      buf_q         <= '0;
      tx_full_q     <= 1'b0;
      tx_sr_q       <= '0;
      rx_sr_q       <= '0;
      cnt_q         <= '0;
      armed_q       <= 1'b0;
      miso_q        <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      abort_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sclk_sync_q   <= sclk_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      ss_sync_q     <= ss_sync_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      buf_q         <= buf_d;
      tx_full_q     <= tx_full_d;
      tx_sr_q       <= tx_sr_d;
      rx_sr_q       <= rx_sr_d;
      cnt_q         <= cnt_d;
      armed_q       <= armed_d;
      miso_q        <= miso_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
      abort_q       <= abort_d;
      busy_q        <= busy_d;
    end
  end

  assign miso_pad_o    = miso_q;
  assign tx_full_o     = tx_full_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_underrun_o = tx_underrun_q;
  assign abort_o       = abort_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// tb/tb_spi_slave_core.sv - directed bench for spi_slave_core with an rx scoreboard
// A bit-banged master drives both an 8-bit and a 32-bit instance from one initial block.
module tb_spi_slave_core;
  localparam int HALF = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sclk, mosi, rx_negedge, tx_negedge, lsb, use32;
  logic [7:0]  ss8, ss32;
  logic [7:0]  tx_data8, rx_data8;
  logic [31:0] tx_data32, rx_data32;
  logic        tx_we8, tx_we32;
  logic        miso8, tx_full8, rx_valid8, under8, abort8, busy8;
  logic        miso32, tx_full32, rx_valid32, under32, abort32, busy32;
  logic        miso_cur;

  assign miso_cur = use32 ? miso32 : miso8;

  spi_slave_core #(.CHAR_LEN(8), .SS_NB(8), .SS_SEL(0)) dut8 (
    .wb_clk_i(clk), .wb_rst_i(rst), .sclk_pad_i(sclk), .mosi_pad_i(mosi),
    .ss_pad_i(ss8), .miso_pad_o(miso8), .rx_negedge(rx_negedge),
    .tx_negedge(tx_negedge), .lsb(lsb), .tx_data_i(tx_data8), .tx_we_i(tx_we8),
    .tx_full_o(tx_full8), .rx_data_o(rx_data8), .rx_valid_o(rx_valid8),
    .tx_underrun_o(under8), .abort_o(abort8), .busy_o(busy8)
  );

  spi_slave_core #(.CHAR_LEN(32), .SS_NB(8), .SS_SEL(0)) dut32 (
    .wb_clk_i(clk), .wb_rst_i(rst), .sclk_pad_i(sclk), .mosi_pad_i(mosi),
    .ss_pad_i(ss32), .miso_pad_o(miso32), .rx_negedge(rx_negedge),
    .tx_negedge(tx_negedge), .lsb(lsb), .tx_data_i(tx_data32), .tx_we_i(tx_we32),
    .tx_full_o(tx_full32), .rx_data_o(rx_data32), .rx_valid_o(rx_valid32),
    .tx_underrun_o(under32), .abort_o(abort32), .busy_o(busy32)
  );

  int n_asserts = 0;
  int n_fail = 0;
  int cnt_valid8 = 0, cnt_under8 = 0, cnt_abort8 = 0, cnt_valid32 = 0;
  int b_valid8, b_under8, b_abort8, b_valid32;
  int rd8 = 0, rd32 = 0;
  logic [7:0]  exp8[$], obs8[$];
  logic [31:0] exp32[$], obs32[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid8) begin
        cnt_valid8++;
        obs8.push_back(rx_data8);
      end
      if (under8) cnt_under8++;
      if (abort8) cnt_abort8++;
      if (rx_valid32) begin
        cnt_valid32++;
        obs32.push_back(rx_data32);
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] to_stream(input logic [127:0] w, input int n, input logic lsbf);
    logic [127:0] s;
    s = '0;
    for (int i = 0; i < n; i++) s[i] = lsbf ? w[i] : w[n-1-i];
    return s;
  endfunction

  task automatic snap();
    b_valid8 = cnt_valid8; b_under8 = cnt_under8;
    b_abort8 = cnt_abort8; b_valid32 = cnt_valid32;
  endtask

  task automatic drain8(input string tag);
    logic [7:0] e;
    while (exp8.size() > 0) begin
      e = exp8.pop_front();
      check(tag, (rd8 < obs8.size()) ? {120'b0, obs8[rd8]} : {128{1'bx}}, {120'b0, e});
      rd8++;
    end
  endtask

  task automatic drain32(input string tag);
    logic [31:0] e;
    while (exp32.size() > 0) begin
      e = exp32.pop_front();
      check(tag, (rd32 < obs32.size()) ? {96'b0, obs32[rd32]} : {128{1'bx}}, {96'b0, e});
      rd32++;
    end
  endtask

  task automatic write8(input logic [7:0] d);
    @(negedge clk); tx_data8 = d; tx_we8 = 1'b1;
    @(negedge clk); tx_we8 = 1'b0;
  endtask

  task automatic write32(input logic [31:0] d);
    @(negedge clk); tx_data32 = d; tx_we32 = 1'b1;
    @(negedge clk); tx_we32 = 1'b0;
  endtask

  // Master: launches mosi and captures miso on the edges selected by the mode inputs.
  task automatic run_bits(input int n, input logic [127:0] mo, output logic [127:0] mi);
    mi = '0;
    for (int i = 0; i < n; i++) begin
      if (tx_negedge) mosi = mo[i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      if (!tx_negedge) mosi = mo[i];
      if (!rx_negedge) mi[i] = miso_cur;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
      if (rx_negedge) mi[i] = miso_cur;
    end
  endtask

  task automatic frame8(input logic do_wr, input logic [7:0] stx, input logic [7:0] mtx,
                        input int nbits, input logic [7:0] ssv, output logic [7:0] got);
    logic [127:0] mi, s;
    if (do_wr) write8(stx);
    if (nbits == 8) exp8.push_back(mtx);
    ss8 = ssv;
    run_bits(nbits, to_stream({120'b0, mtx}, 8, lsb), mi);
    repeat (HALF) @(negedge clk);
    ss8 = 8'hFF;
    repeat (2 * HALF) @(negedge clk);
    s = to_stream(mi, 8, lsb);
    got = s[7:0];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [127:0] mi, w;
    logic [7:0]   got;
    int           waited;

    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; ss8 = 8'hFF; ss32 = 8'hFF;
    rx_negedge = 1'b1; tx_negedge = 1'b0; lsb = 1'b0; use32 = 1'b0;
    tx_data8 = '0; tx_we8 = 1'b0; tx_data32 = '0; tx_we32 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso", miso8, 0);
    check("rst_tx_full", tx_full8, 0);
    check("rst_rx_data", rx_data8, 0);
    check("rst_rx_valid", rx_valid8, 0);
    check("rst_busy", busy8, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // rx_negedge=1, tx_negedge=0, MSB first, with latency boundaries
    write8(8'hA5);
    check("a_tx_full_set", tx_full8, 1);
    snap();
    exp8.push_back(8'h3C);
    ss8 = 8'hFE;
    repeat (3) @(negedge clk);
    check("a_sel_lat3", miso8, 0);
    @(negedge clk);
    check("a_sel_lat4", miso8, 1);
    check("a_tx_full_clr", tx_full8, 0);
    run_bits(8, to_stream(128'h3C, 8, 1'b0), mi);
    repeat (3) @(negedge clk);
    check("a_rxv_lat3", rx_valid8, 0);
    @(negedge clk);
    check("a_rxv_lat4", rx_valid8, 1);
    repeat (HALF) @(negedge clk);
    ss8 = 8'hFF;
    repeat (2 * HALF) @(negedge clk);
    w = to_stream(mi, 8, 1'b0);
    check("a_master_rx", w, 128'hA5);
    drain8("a_rx_data");
    check("a_valid_cnt", cnt_valid8 - b_valid8, 1);
    check("a_underrun_cnt", cnt_under8 - b_under8, 1);
    check("a_abort_cnt", cnt_abort8 - b_abort8, 0);

    // rx_negedge=0, tx_negedge=1, LSB first
    rx_negedge = 1'b0; tx_negedge = 1'b1; lsb = 1'b1;
    snap();
    frame8(1'b1, 8'h81, 8'h01, 8, 8'hFE, got);
    check("b_master_rx", got, 8'h81);
    drain8("b_rx_data");
    check("b_rx_data_port", rx_data8, 8'h01);
    check("b_valid_cnt", cnt_valid8 - b_valid8, 1);

    // Underrun: buffer empty at select
    rx_negedge = 1'b1; tx_negedge = 1'b0; lsb = 1'b0;
    snap();
    frame8(1'b0, 8'h00, 8'h5A, 8, 8'hFE, got);
    check("u_master_rx_zero", got, 8'h00);
    check("u_underrun_cnt", cnt_under8 - b_under8, 2);
    drain8("u_rx_data");
    check("u_rx_data_port", rx_data8, 8'h5A);

    // Abort after 5 of 8 bits, then a clean frame
    snap();
    frame8(1'b1, 8'hFF, 8'hC3, 5, 8'hFE, got);
    check("ab_abort_cnt", cnt_abort8 - b_abort8, 1);
    check("ab_valid_cnt", cnt_valid8 - b_valid8, 0);
    check("ab_rx_data_kept", rx_data8, 8'h5A);
    frame8(1'b1, 8'h3C, 8'h96, 8, 8'hFE, got);
    check("ab_next_master_rx", got, 8'h3C);
    drain8("ab_next_rx_data");
    check("ab_next_valid_cnt", cnt_valid8 - b_valid8, 1);

    // Back-to-back 32-bit characters in one select window
    use32 = 1'b1;
    write32(32'hDEADBEEF);
    snap();
    exp32.push_back(32'hCAFEF00D);
    exp32.push_back(32'h0BADC0DE);
    ss32 = 8'hFE;
    waited = 0;
    while (tx_full32 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("bb_first_load", tx_full32, 0);
    write32(32'h12345678);
    check("bb_second_full", tx_full32, 1);
    run_bits(64, to_stream(128'hCAFEF00D, 32, 1'b0) | (to_stream(128'h0BADC0DE, 32, 1'b0) << 32), mi);
    repeat (HALF) @(negedge clk);
    ss32 = 8'hFF;
    repeat (2 * HALF) @(negedge clk);
    w = to_stream(mi, 32, 1'b0);
    check("bb_master_word0", w, 128'hDEADBEEF);
    w = to_stream(mi >> 32, 32, 1'b0);
    check("bb_master_word1", w, 128'h12345678);
    check("bb_valid_cnt", cnt_valid32 - b_valid32, 2);
    drain32("bb_rx_data");
    use32 = 1'b0;

    // Isolation: another select bit low
    write8(8'hFF);
    snap();
    frame8(1'b0, 8'h00, 8'hAA, 8, 8'hF7, got);
    void'(exp8.pop_back());
    check("iso_miso", got, 8'h00);
    check("iso_tx_full", tx_full8, 1);
    check("iso_valid_cnt", cnt_valid8 - b_valid8, 0);
    check("iso_underrun_cnt", cnt_under8 - b_under8, 0);
    check("iso_abort_cnt", cnt_abort8 - b_abort8, 0);

    // Reset in the middle of a character
    ss8 = 8'hFE;
    run_bits(3, to_stream(128'h0F, 8, 1'b0), mi);
    write8(8'h55);
    check("rm_busy_pre", busy8, 1);
    check("rm_miso_pre", miso8, 1);
    check("rm_full_pre", tx_full8, 1);
    rst = 1'b1;
    #1;
    check("rm_miso", miso8, 0);
    check("rm_tx_full", tx_full8, 0);
    check("rm_rx_data", rx_data8, 0);
    check("rm_rx_valid", rx_valid8, 0);
    check("rm_underrun", under8, 0);
    check("rm_abort", abort8, 0);
    check("rm_busy", busy8, 0);
    @(negedge clk);
    ss8 = 8'hFF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Recovery after reset
    snap();
    frame8(1'b1, 8'h42, 8'h24, 8, 8'hFE, got);
    check("rec_master_rx", got, 8'h42);
    drain8("rec_rx_data");
    check("rec_valid_cnt", cnt_valid8 - b_valid8, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
